plab5_mcore_mem_req_arb: RTL and testbench
==========================================

# plab5_mcore_mem_req_arb

Two-requester arbiter placed directly upstream of the single-ported test memory. It merges two cores' split control/data memory request streams onto the memory's one request port using round-robin arbitration. It routes each response back to the requester that issued it, tracking in-flight ownership in a small in-order FIFO. Control and data stay on separate wires end to end, matching the memory's split interface.

## Interface
- p_opaque_nbits, 8, opaque field width (o)
- p_addr_nbits, 32, address width (a)
- p_data_nbits, 32, data width (d)
- p_max_inflight, 2, tracking FIFO depth; power of two, ≥1
- c_req_cnbits, derived: VC_MEM_REQ_MSG_NBITS(o,a,d) − d
- c_resp_cnbits, derived: VC_MEM_RESP_MSG_NBITS(o,d) − d

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low
- in0_memreq_val / in1_memreq_val  in  1  requester valid
- in0_memreq_rdy / in1_memreq_rdy  out  1  requester ready
- in0_memreq_control / in1_memreq_control  in  c_req_cnbits  type/opaque/addr/len
- in0_memreq_data / in1_memreq_data  in  d  write data
- in0_memresp_val / in1_memresp_val  out  1  response valid to requester
- in0_memresp_rdy / in1_memresp_rdy  in  1  requester accepts response
- in0_memresp_control / in1_memresp_control  out  c_resp_cnbits  response control
- in0_memresp_data / in1_memresp_data  out  d  response data
- memreq_val / memreq_rdy / memreq_control / memreq_data  out/in/out/out  1/1/c_req_cnbits/d  to memory
- memresp_val / memresp_rdy / memresp_control / memresp_data  in/out/in/in  1/1/c_resp_cnbits/d  from memory

## Operation
- State: prio (1b, favoured port), lock (1b), lock_id (1b), tracking FIFO of port IDs (p_max_inflight entries, wr/rd pointers + count).
- Selection: if lock, sel = lock_id. Else, if both requesters are valid, sel = prio. Else sel = the single valid port.
- Issue: memreq_val = inX_val[sel] && !fifo_full. The memreq_control and memreq_data outputs come from sel unmodified; opaque is never rewritten.
- inX_memreq_rdy = (X == sel) && memreq_rdy && !fifo_full. The non-selected port always sees rdy=0.
- Lock: when memreq_val && !memreq_rdy, set lock=1 and lock_id=sel. Selection then holds until the transfer fires, so val/rdy stability holds downstream. The lock clears on the fire.
- On fire (memreq_val && memreq_rdy): push sel into FIFO, set prio = !sel, clear lock.
- Response routing: head = FIFO head ID. in{head}_memresp_val = memresp_val && !fifo_empty. memresp_rdy = in{head}_memresp_rdy && !fifo_empty. Control and data are broadcast to both ports; only the head port sees val.
- On response fire: pop FIFO.
- Responses return in issue order; the arbiter relies on the memory being in-order.

## Timing
- Zero-cycle request and response paths. Requester-to-memory and memory-to-requester paths are combinational, with no added latency.
- Full FIFO blocks issue even if a pop occurs in the same cycle. There is no memresp_* → memreq_* combinational path.
- Simultaneous push and pop when not full: count unchanged, both pointers advance (wrap modulo p_max_inflight).
- Response with empty FIFO: memresp_rdy=0 and no requester val. VC_ASSERT flags memresp_val && fifo_empty.
- Reset asserted (reset=0), at any time including mid-transfer: prio=0, lock=0, FIFO empty. All rdy/val outputs are forced 0 while reset is low. In-flight responses are discarded; the memory is reset by the same signal.
- First grant after reset goes to port 0 if both ports request.

## Structure
- Shared package: req/resp control widths, field offsets, and VC_MEM type encodings (read=0, write=1, write_init=2, amo_add=3, amo_and=4, amo_or=5) shared with the memory and the cores.
- Sub-module plab5_mcore_mem_arb_id_fifo: the parameterized tracking FIFO (push, pop, head, full, empty).
- The arbiter top holds the selection/lock logic and the muxes.
- val/rdy X-assertions on all inputs when reset is high.

## Test plan
- Single read, port 0, addr 0x100, opaque 0x05: memreq_control carries opaque 0x05 the same cycle. The response routes to port 0 only, and in1_memresp_val stays 0.
- Both ports valid every cycle, memreq_rdy=1: grants alternate 0,1,0,1 over 4 fires. The FIFO holds the issue order, and responses deliver to ports 0,1,0,1.
- Port 1 valid, memreq_rdy held 0 for 3 cycles, port 0 asserts val in cycle 2: the grant stays on port 1 until it fires, then port 0 fires next.
- Memory withholds responses while 2 reqs issue (p_max_inflight=2): the third request sees memreq_val=0 and in*_rdy=0. It is still blocked in the pop cycle and issues the cycle after.
- Response arrives with head=port 1 while in1_memresp_rdy=0: memresp_rdy=0 and the FIFO is not popped. It pops in the cycle rdy rises.
- reset driven low with 1 response in flight and lock set: all outputs go 0 immediately. After release, FIFO count=0 and port 0 wins the first simultaneous request.

Source files
------------

// File: rtl/plab5_mcore_mem_req_arb_pkg.sv
// Shared memory-message definitions: type encodings, control widths and field offsets
// used by the arbiter, the test memory and the cores.
package plab5_mcore_mem_req_arb_pkg;

    typedef enum logic [2:0] {
        MEM_TYPE_READ       = 3'd0,
        MEM_TYPE_WRITE      = 3'd1,
        MEM_TYPE_WRITE_INIT = 3'd2,
        MEM_TYPE_AMO_ADD    = 3'd3,
        MEM_TYPE_AMO_AND    = 3'd4,
        MEM_TYPE_AMO_OR     = 3'd5
    } mem_type_e;

    localparam int unsigned MEM_TYPE_NBITS = 3;

    // Request control is {type, opaque, addr, len}; response control is {type, opaque, len}.
    function automatic int unsigned mem_len_nbits(input int unsigned d);
        return $clog2(d / 8);
    endfunction

    function automatic int unsigned mem_req_cnbits(input int unsigned o, input int unsigned a,
                                                   input int unsigned d);
        return MEM_TYPE_NBITS + o + a + mem_len_nbits(d);
    endfunction

    function automatic int unsigned mem_resp_cnbits(input int unsigned o, input int unsigned d);
        return MEM_TYPE_NBITS + o + mem_len_nbits(d);
    endfunction

    function automatic int unsigned mem_req_addr_lsb(input int unsigned d);
        return mem_len_nbits(d);
    endfunction

    function automatic int unsigned mem_req_opaque_lsb(input int unsigned a, input int unsigned d);
        return mem_len_nbits(d) + a;
    endfunction

    function automatic int unsigned mem_req_type_lsb(input int unsigned o, input int unsigned a,
                                                     input int unsigned d);
        return mem_len_nbits(d) + a + o;
    endfunction

endpackage

// File: rtl/plab5_mcore_mem_arb_id_fifo.sv
// In-order tracking FIFO of requester IDs for requests in flight at the memory.
module plab5_mcore_mem_arb_id_fifo
    import plab5_mcore_mem_req_arb_pkg::*;
#(
    parameter int unsigned p_depth = 2
)(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned c_cnt_nbits = $clog2(p_depth + 1);
    localparam logic [c_ptr_nbits-1:0] c_ptr_last = c_ptr_nbits'(p_depth - 1);
    localparam logic [c_ptr_nbits-1:0] c_ptr_one  = c_ptr_nbits'(1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_depth);
    localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);

    logic [p_depth-1:0]     ids_r;
    logic [c_ptr_nbits-1:0] wr_ptr_r;
    logic [c_ptr_nbits-1:0] rd_ptr_r;
    logic [c_cnt_nbits-1:0] count_r;
    logic                   do_push_s;
    logic                   do_pop_s;

    function automatic logic [c_ptr_nbits-1:0] next_ptr(input logic [c_ptr_nbits-1:0] ptr);
        if (ptr == c_ptr_last) begin
            return {c_ptr_nbits{1'b0}};
        end else begin
            return ptr + c_ptr_one;
        end
    endfunction

    assign full      = (count_r == c_cnt_full);
    assign empty     = (count_r == {c_cnt_nbits{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = ids_r[rd_ptr_r];

    // Storage, pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ids_r    <= {p_depth{1'b0}};
            wr_ptr_r <= {c_ptr_nbits{1'b0}};
            rd_ptr_r <= {c_ptr_nbits{1'b0}};
            count_r  <= {c_cnt_nbits{1'b0}};
        end else begin
            if (do_push_s) begin
                ids_r[wr_ptr_r] <= push_id;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + c_cnt_one;
                2'b01:   count_r <= count_r - c_cnt_one;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_req_arb_checker.sv
// Simulation-only protocol checks on the arbiter's handshake inputs.
module plab5_mcore_mem_req_arb_checker (
    input logic clk,
    input logic reset,
    input logic in0_memreq_val,
    input logic in1_memreq_val,
    input logic memreq_rdy,
    input logic memresp_val,
    input logic in0_memresp_rdy,
    input logic in1_memresp_rdy,
    input logic fifo_empty
);

    // Handshake inputs must be known, and the memory must not answer with nothing in flight.
    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown({in0_memreq_val, in1_memreq_val, memreq_rdy,
                                 memresp_val, in0_memresp_rdy, in1_memresp_rdy}));
            assert (!(memresp_val && fifo_empty));
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_req_arb.sv
// Round-robin merge of two requesters onto one memory port, with in-order
// response routing driven by a FIFO of issuing-port IDs.
module plab5_mcore_mem_req_arb
    import plab5_mcore_mem_req_arb_pkg::*;
#(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_addr_nbits   = 32,
    parameter int unsigned p_data_nbits   = 32,
    parameter int unsigned p_max_inflight = 2,
    localparam int unsigned c_req_cnbits  = mem_req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int unsigned c_resp_cnbits = mem_resp_cnbits(p_opaque_nbits, p_data_nbits)
)(
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     in0_memreq_val,
    output logic                     in0_memreq_rdy,
    input  logic [c_req_cnbits-1:0]  in0_memreq_control,
    input  logic [p_data_nbits-1:0]  in0_memreq_data,
    input  logic                     in1_memreq_val,
    output logic                     in1_memreq_rdy,
    input  logic [c_req_cnbits-1:0]  in1_memreq_control,
    input  logic [p_data_nbits-1:0]  in1_memreq_data,

    output logic                     in0_memresp_val,
    input  logic                     in0_memresp_rdy,
    output logic [c_resp_cnbits-1:0] in0_memresp_control,
    output logic [p_data_nbits-1:0]  in0_memresp_data,
    output logic                     in1_memresp_val,
    input  logic                     in1_memresp_rdy,
    output logic [c_resp_cnbits-1:0] in1_memresp_control,
    output logic [p_data_nbits-1:0]  in1_memresp_data,

    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [c_req_cnbits-1:0]  memreq_control,
    output logic [p_data_nbits-1:0]  memreq_data,

    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [c_resp_cnbits-1:0] memresp_control,
    input  logic [p_data_nbits-1:0]  memresp_data
);

    logic       prio_r;
    logic       lock_r;
    logic       lock_id_r;
    logic [1:0] req_val_s;
    logic       sel_s;
    logic       fire_s;
    logic       resp_fire_s;
    logic       fifo_head_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;

    assign req_val_s = {in1_memreq_val, in0_memreq_val};

    // Grant selection: a refused offer keeps its grant, ties go to the favoured port.
    always_comb begin
        sel_s = 1'b0;
        if (lock_r) begin
            sel_s = lock_id_r;
        end else if (req_val_s == 2'b11) begin
            sel_s = prio_r;
        end else if (req_val_s == 2'b10) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    assign memreq_val     = reset && req_val_s[sel_s] && !fifo_full_s;
    assign in0_memreq_rdy = reset && !sel_s && memreq_rdy && !fifo_full_s;
    assign in1_memreq_rdy = reset && sel_s && memreq_rdy && !fifo_full_s;
    assign memreq_control = sel_s ? in1_memreq_control : in0_memreq_control;
    assign memreq_data    = sel_s ? in1_memreq_data : in0_memreq_data;
    assign fire_s         = memreq_val && memreq_rdy;

    // Round-robin priority and grant lock, updated on fire or on a refused offer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r    <= 1'b0;
            lock_r    <= 1'b0;
            lock_id_r <= 1'b0;
        end else if (fire_s) begin
            prio_r    <= !sel_s;
            lock_r    <= 1'b0;
        end else if (memreq_val) begin
            lock_r    <= 1'b1;
            lock_id_r <= sel_s;
        end
    end

    plab5_mcore_mem_arb_id_fifo #(
        .p_depth (p_max_inflight)
    ) id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fire_s),
        .push_id (sel_s),
        .pop     (resp_fire_s),
        .head    (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Only the port that owns the oldest in-flight request sees the response.
    assign in0_memresp_val     = reset && memresp_val && !fifo_empty_s && !fifo_head_s;
    assign in1_memresp_val     = reset && memresp_val && !fifo_empty_s && fifo_head_s;
    assign memresp_rdy         = reset && !fifo_empty_s &&
                                 (fifo_head_s ? in1_memresp_rdy : in0_memresp_rdy);
    assign resp_fire_s         = memresp_val && memresp_rdy;
    assign in0_memresp_control = memresp_control;
    assign in1_memresp_control = memresp_control;
    assign in0_memresp_data    = memresp_data;
    assign in1_memresp_data    = memresp_data;

    plab5_mcore_mem_req_arb_checker checker_inst (
        .clk             (clk),
        .reset           (reset),
        .in0_memreq_val  (in0_memreq_val),
        .in1_memreq_val  (in1_memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memresp_val     (memresp_val),
        .in0_memresp_rdy (in0_memresp_rdy),
        .in1_memresp_rdy (in1_memresp_rdy),
        .fifo_empty      (fifo_empty_s)
    );

endmodule

// File: tb/tb_plab5_mcore_mem_req_arb.sv
// Randomized bench: a transaction-level model predicts every cycle's outputs into a
// queue, and a negedge monitor pops and compares against the arbiter.
module tb_plab5_mcore_mem_req_arb;
    import plab5_mcore_mem_req_arb_pkg::*;

    localparam int unsigned O     = 8;
    localparam int unsigned A     = 32;
    localparam int unsigned D     = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CN    = mem_req_cnbits(O, A, D);
    localparam int unsigned RN    = mem_resp_cnbits(O, D);
    localparam int unsigned LN    = mem_len_nbits(D);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in0_memreq_val = 1'b0, in1_memreq_val = 1'b0;
    logic in0_memreq_rdy, in1_memreq_rdy;
    logic [CN-1:0] in0_memreq_control = '0, in1_memreq_control = '0;
    logic [D-1:0]  in0_memreq_data = '0, in1_memreq_data = '0;
    logic in0_memresp_val, in1_memresp_val;
    logic in0_memresp_rdy = 1'b0, in1_memresp_rdy = 1'b0;
    logic [RN-1:0] in0_memresp_control, in1_memresp_control;
    logic [D-1:0]  in0_memresp_data, in1_memresp_data;
    logic memreq_val;
    logic memreq_rdy = 1'b0;
    logic [CN-1:0] memreq_control;
    logic [D-1:0]  memreq_data;
    logic memresp_val = 1'b0;
    logic memresp_rdy;
    logic [RN-1:0] memresp_control = '0;
    logic [D-1:0]  memresp_data = '0;

    plab5_mcore_mem_req_arb #(
        .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D), .p_max_inflight(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in0_memreq_val(in0_memreq_val), .in0_memreq_rdy(in0_memreq_rdy),
        .in0_memreq_control(in0_memreq_control), .in0_memreq_data(in0_memreq_data),
        .in1_memreq_val(in1_memreq_val), .in1_memreq_rdy(in1_memreq_rdy),
        .in1_memreq_control(in1_memreq_control), .in1_memreq_data(in1_memreq_data),
        .in0_memresp_val(in0_memresp_val), .in0_memresp_rdy(in0_memresp_rdy),
        .in0_memresp_control(in0_memresp_control), .in0_memresp_data(in0_memresp_data),
        .in1_memresp_val(in1_memresp_val), .in1_memresp_rdy(in1_memresp_rdy),
        .in1_memresp_control(in1_memresp_control), .in1_memresp_data(in1_memresp_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memreq_control(memreq_control), .memreq_data(memreq_data),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .memresp_control(memresp_control), .memresp_data(memresp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          mval;
        logic          r0;
        logic          r1;
        logic          v0;
        logic          v1;
        logic          mrdy;
        logic          rv;
        logic [CN-1:0] mctrl;
        logic [D-1:0]  mdata;
        logic [RN-1:0] rctrl;
        logic [D-1:0]  rdata;
    } exp_t;

    typedef struct packed {
        logic [RN-1:0] ctrl;
        logic [D-1:0]  data;
    } resp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Transaction-level model state
    bit            has_req[2];
    logic [CN-1:0] req_ctrl[2];
    logic [D-1:0]  req_data[2];
    bit            owners[$];
    resp_t         mem_q[$];
    bit            resp_on;
    bit            next_tie;
    bit            held;
    bit            held_port;

    // Phase table: cycles, request %, memreq_rdy %, response-start %, requester resp rdy %, reset
    int ph_len [7] = '{3,   200, 60,  300, 3,   300, 200};
    int ph_val [7] = '{0,   100, 100, 60,  0,   80,  100};
    int ph_rdy [7] = '{0,   100, 100, 50,  0,   30,  100};
    int ph_rsp [7] = '{0,   100, 0,   50,  0,   70,  30};
    int ph_rrd [7] = '{0,   100, 100, 50,  0,   40,  30};
    int ph_rst [7] = '{1,   0,   0,   0,   1,   0,   0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d actual=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    function automatic logic [CN-1:0] rand_ctrl();
        logic [2:0]    t;
        logic [O-1:0]  op;
        logic [A-1:0]  ad;
        logic [LN-1:0] ln;
        t  = 3'($urandom_range(0, 5));
        op = O'($urandom);
        ad = A'($urandom);
        ln = LN'($urandom);
        return {t, op, ad, ln};
    endfunction

    // The memory answers with the request's type, opaque and len; data is any fixed function.
    function automatic resp_t mem_answer(input logic [CN-1:0] c, input logic [D-1:0] d);
        resp_t r;
        r.ctrl = {c[CN-1 -: MEM_TYPE_NBITS + O], c[LN-1:0]};
        r.data = d ^ c[LN +: D] ^ 32'h5a5a_c3c3;
        return r;
    endfunction

    task automatic model_reset();
        has_req[0] = 1'b0; has_req[1] = 1'b0;
        owners.delete();
        mem_q.delete();
        resp_on   = 1'b0;
        next_tie  = 1'b0;
        held      = 1'b0;
        held_port = 1'b0;
    endtask

    // Stimulus + reference model: drives one cycle and predicts what the arbiter must show.
    initial begin
        exp_t e;
        bit   sel, full, fire, rfire, head;
        bit   rrdy[2];
        model_reset();
        for (int ph = 0; ph < 7; ph++) begin
            for (int n = 0; n < ph_len[ph]; n++) begin
                @(posedge clk);
                #1;
                cyc++;
                e = '0;
                if (ph_rst[ph] != 0) begin
                    reset = 1'b0;
                    model_reset();
                    in0_memreq_val = 1'b0; in1_memreq_val = 1'b0;
                    memresp_val = 1'b0;
                    memreq_rdy = 1'($urandom);
                    in0_memresp_rdy = 1'($urandom); in1_memresp_rdy = 1'($urandom);
                    exp_q.push_back(e);
                    continue;
                end
                reset = 1'b1;
                e.rst = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (!has_req[p] && ($urandom_range(0, 99) < ph_val[ph])) begin
                        has_req[p]  = 1'b1;
                        req_ctrl[p] = rand_ctrl();
                        req_data[p] = D'($urandom);
                    end
                end
                in0_memreq_val = has_req[0]; in0_memreq_control = req_ctrl[0]; in0_memreq_data = req_data[0];
                in1_memreq_val = has_req[1]; in1_memreq_control = req_ctrl[1]; in1_memreq_data = req_data[1];
                memreq_rdy = ($urandom_range(0, 99) < ph_rdy[ph]);
                if (!resp_on && mem_q.size() > 0 && ($urandom_range(0, 99) < ph_rsp[ph]))
                    resp_on = 1'b1;
                memresp_val     = resp_on;
                memresp_control = resp_on ? mem_q[0].ctrl : '0;
                memresp_data    = resp_on ? mem_q[0].data : '0;
                rrdy[0] = ($urandom_range(0, 99) < ph_rrd[ph]);
                rrdy[1] = ($urandom_range(0, 99) < ph_rrd[ph]);
                in0_memresp_rdy = rrdy[0];
                in1_memresp_rdy = rrdy[1];

                // Request side
                full = (owners.size() == DEPTH);
                if (held)                         sel = held_port;
                else if (has_req[0] && has_req[1]) sel = next_tie;
                else if (has_req[1])              sel = 1'b1;
                else                              sel = 1'b0;
                e.mval  = has_req[sel] && !full;
                e.r0    = (sel == 1'b0) && memreq_rdy && !full;
                e.r1    = (sel == 1'b1) && memreq_rdy && !full;
                e.mctrl = req_ctrl[sel];
                e.mdata = req_data[sel];
                fire    = e.mval && memreq_rdy;

                // Response side
                head   = (owners.size() > 0) ? owners[0] : 1'b0;
                e.rv   = resp_on;
                e.v0   = resp_on && owners.size() > 0 && head == 1'b0;
                e.v1   = resp_on && owners.size() > 0 && head == 1'b1;
                e.mrdy = owners.size() > 0 && rrdy[head];
                e.rctrl = memresp_control;
                e.rdata = memresp_data;
                rfire  = resp_on && e.mrdy;
                exp_q.push_back(e);

                if (rfire) begin
                    void'(owners.pop_front());
                    void'(mem_q.pop_front());
                    resp_on = 1'b0;
                end
                if (fire) begin
                    owners.push_back(sel);
                    mem_q.push_back(mem_answer(req_ctrl[sel], req_data[sel]));
                    has_req[sel] = 1'b0;
                    next_tie = !sel;
                    held = 1'b0;
                end else if (e.mval) begin
                    held = 1'b1;
                    held_port = sel;
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: compares the arbiter's outputs with the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("memreq_val", 64'(memreq_val), 64'(e.mval));
                chk("in0_memreq_rdy", 64'(in0_memreq_rdy), 64'(e.r0));
                chk("in1_memreq_rdy", 64'(in1_memreq_rdy), 64'(e.r1));
                chk("in0_memresp_val", 64'(in0_memresp_val), 64'(e.v0));
                chk("in1_memresp_val", 64'(in1_memresp_val), 64'(e.v1));
                chk("memresp_rdy", 64'(memresp_rdy), 64'(e.mrdy));
                if (e.mval) begin
                    chk("memreq_control", 64'(memreq_control), 64'(e.mctrl));
                    chk("memreq_data", 64'(memreq_data), 64'(e.mdata));
                end
                if (e.rst && e.rv) begin
                    chk("in0_memresp_control", 64'(in0_memresp_control), 64'(e.rctrl));
                    chk("in1_memresp_control", 64'(in1_memresp_control), 64'(e.rctrl));
                    chk("in0_memresp_data", 64'(in0_memresp_data), 64'(e.rdata));
                    chk("in1_memresp_data", 64'(in1_memresp_data), 64'(e.rdata));
                end
            end
        end
    end

endmodule
